// File: rtl/move_controller.sv
// Checkers board cursor, piece selection and move request controller.
// Buttons are synchronised and edge-detected; legal moves are registered per slot.
`timescale 1ns/1ps
module move_controller (
  input  logic         clk,
  input  logic         rst,
  input  logic         btn_up,
  input  logic         btn_down,
  input  logic         btn_left,
  input  logic         btn_right,
  input  logic         btn_sel,
  input  logic [191:0] serialized_board,
  input  logic         turn,
  input  logic         move_ack,
  output logic [5:0]   cursor_loc,
  output logic [5:0]   select_loc,
  output logic         select_active,
  output logic [27:0]  legal_move,
  output logic         move_valid,
  output logic [5:0]   move_from,
  output logic [5:0]   move_to,
  output logic         move_jump
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SELECTED = 2'd1,
    COMMIT   = 2'd2
  } state_e;

  state_e      state_q;
  logic [4:0]  btn_raw;
  logic [4:0]  sync1_q;
  logic [4:0]  sync2_q;
  logic [4:0]  prev_q;
  logic [4:0]  edge_w;
  logic        up_e;
  logic        dn_e;
  logic        lf_e;
  logic        rt_e;
  logic        sel_e;
  logic [5:0]  cursor_q;
  logic [5:0]  cursor_d;
  logic [2:0]  cur_x;
  logic [2:0]  cur_y;
  logic [2:0]  nx;
  logic [2:0]  ny;
  logic [5:0]  sel_loc_q;
  logic [27:0] legal_q;
  logic [3:0]  jump_q;
  logic [27:0] calc_legal;
  logic [3:0]  calc_jump;
  logic        mv_valid_q;
  logic [5:0]  mv_from_q;
  logic [5:0]  mv_to_q;
  logic        mv_jump_q;
  logic        cur_own;
  logic        sel_red;
  logic        sel_king;
  logic        allow;
  logic [3:0]  dx;
  logic [3:0]  dy;
  logic [7:0]  slot;
  logic        hit;
  logic        hit_jump;

  function automatic logic occ_at(
    input logic [191:0] b,
    input logic [5:0]   l
  );
    return b[{3'b0, l} * 9'd3 + 9'd2];
  endfunction

  function automatic logic red_at(
    input logic [191:0] b,
    input logic [5:0]   l
  );
    return b[{3'b0, l} * 9'd3 + 9'd1];
  endfunction

  function automatic logic king_at(
    input logic [191:0] b,
    input logic [5:0]   l
  );
    return b[{3'b0, l} * 9'd3];
  endfunction

  // {jump, valid, loc}; 4-bit signed coords so bit3 flags off-board.
  function automatic logic [7:0] slot_eval(
    input logic [191:0] b,
    input logic [5:0]   from,
    input logic [3:0]   sx,
    input logic [3:0]   sy,
    input logic         mine_red
  );
    logic [3:0] ax;
    logic [3:0] ay;
    logic [3:0] lx;
    logic [3:0] ly;
    logic [7:0] r;
    ax = {1'b0, from[5:3]} + sx;
    ay = {1'b0, from[2:0]} + sy;
    lx = ax + sx;
    ly = ay + sy;
    r  = '0;
    if (!ax[3] && !ay[3]) begin
      if (!occ_at(b, {ax[2:0], ay[2:0]})) begin
        r = {2'b01, ax[2:0], ay[2:0]};
      end else if (red_at(b, {ax[2:0], ay[2:0]}) != mine_red &&
                   !lx[3] && !ly[3] &&
                   !occ_at(b, {lx[2:0], ly[2:0]})) begin
        r = {2'b11, lx[2:0], ly[2:0]};
      end
    end
    return r;
  endfunction

  assign btn_raw = {btn_sel, btn_right, btn_left, btn_down, btn_up};
  assign edge_w  = sync2_q & ~prev_q;
  assign up_e    = edge_w[0];
  assign dn_e    = edge_w[1];
  assign lf_e    = edge_w[2];
  assign rt_e    = edge_w[3];
  assign sel_e   = edge_w[4];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign cur_x = cursor_q[5:3];
  assign cur_y = cursor_q[2:0];

  always_comb begin
    nx = cur_x;
    ny = cur_y;
    if (rt_e && !lf_e && cur_x != 3'd7) begin
      nx = cur_x + 3'd1;
    end else if (lf_e && !rt_e && cur_x != 3'd0) begin
      nx = cur_x - 3'd1;
    end
    if (up_e && !dn_e && cur_y != 3'd7) begin
      ny = cur_y + 3'd1;
    end else if (dn_e && !up_e && cur_y != 3'd0) begin
      ny = cur_y - 3'd1;
    end
    cursor_d = {nx, ny};
  end

  assign cur_own  = occ_at(serialized_board, cursor_q) &
                    (red_at(serialized_board, cursor_q) == turn);
  assign sel_red  = red_at(serialized_board, sel_loc_q);
  assign sel_king = king_at(serialized_board, sel_loc_q);

  // Slot k: bit0 of k picks -x, bit1 picks -y.
  always_comb begin
    calc_legal = '0;
    calc_jump  = '0;
    allow      = 1'b0;
    dx         = 4'h1;
    dy         = 4'h1;
    slot       = '0;
    for (int k = 0; k < 4; k++) begin
      allow = sel_king | (sel_red ? (k < 2) : (k >= 2));
      dx    = k[0] ? 4'hF : 4'h1;
      dy    = k[1] ? 4'hF : 4'h1;
      slot  = slot_eval(serialized_board, sel_loc_q, dx, dy, sel_red);
      if (allow) begin
        calc_legal[7*k +: 7] = slot[6:0];
        calc_jump[k]         = slot[7];
      end
    end
  end

  always_comb begin
    hit      = 1'b0;
    hit_jump = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!hit && legal_q[7*k+6] &&
          legal_q[7*k +: 6] == cursor_q) begin
        hit      = 1'b1;
        hit_jump = jump_q[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cursor_q   <= '0;
      sel_loc_q  <= '0;
      legal_q    <= '0;
      jump_q     <= '0;
      mv_valid_q <= 1'b0;
      mv_from_q  <= '0;
      mv_to_q    <= '0;
      mv_jump_q  <= 1'b0;
    end else begin
      if (state_q != COMMIT) begin
        cursor_q <= cursor_d;
      end
      unique case (state_q)
        IDLE: begin
          legal_q <= '0;
          jump_q  <= '0;
          if (sel_e && cur_own) begin
            state_q   <= SELECTED;
            sel_loc_q <= cursor_q;
          end
        end
        SELECTED: begin
          legal_q <= calc_legal;
          jump_q  <= calc_jump;
          if (sel_e) begin
            if (cursor_q == sel_loc_q) begin
              state_q <= IDLE;
              legal_q <= '0;
              jump_q  <= '0;
            end else if (hit) begin
              state_q    <= COMMIT;
              mv_valid_q <= 1'b1;
              mv_from_q  <= sel_loc_q;
              mv_to_q    <= cursor_q;
              mv_jump_q  <= hit_jump;
              legal_q    <= '0;
              jump_q     <= '0;
            end else if (cur_own) begin
              sel_loc_q <= cursor_q;
              legal_q   <= '0;
              jump_q    <= '0;
            end
          end
        end
        COMMIT: begin
          legal_q <= '0;
          jump_q  <= '0;
          if (move_ack) begin
            state_q    <= IDLE;
            mv_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cursor_loc    = cursor_q;
  assign select_loc    = (state_q == IDLE) ? cursor_q : sel_loc_q;
  assign select_active = (state_q != IDLE);
  assign legal_move    = legal_q;
  assign move_valid    = mv_valid_q;
  assign move_from     = mv_from_q;
  assign move_to       = mv_to_q;
  assign move_jump     = mv_jump_q;

endmodule

// File: tb/tb_move_controller.sv
// Scoreboard bench for move_controller: reference model of the board
// rules feeds expected snapshots and moves to a decoupled monitor.
`timescale 1ns/1ps
module tb_move_controller;

  localparam int M_IDLE = 0;
  localparam int M_SEL  = 1;
  localparam int M_COM  = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         btn_up, btn_down, btn_left, btn_right, btn_sel;
  logic [191:0] board_v;
  logic         turn;
  logic         move_ack;
  logic [5:0]   cursor_loc;
  logic [5:0]   select_loc;
  logic         select_active;
  logic [27:0]  legal_move;
  logic         move_valid;
  logic [5:0]   move_from;
  logic [5:0]   move_to;
  logic         move_jump;

  move_controller dut (
    .clk              (clk),
    .rst              (rst),
    .btn_up           (btn_up),
    .btn_down         (btn_down),
    .btn_left         (btn_left),
    .btn_right        (btn_right),
    .btn_sel          (btn_sel),
    .serialized_board (board_v),
    .turn             (turn),
    .move_ack         (move_ack),
    .cursor_loc       (cursor_loc),
    .select_loc       (select_loc),
    .select_active    (select_active),
    .legal_move       (legal_move),
    .move_valid       (move_valid),
    .move_from        (move_from),
    .move_to          (move_to),
    .move_jump        (move_jump)
  );

  always #20 clk = ~clk;

  typedef struct {
    string       nm;
    logic [5:0]  cur;
    logic [5:0]  sel;
    logic        act;
    logic [27:0] legal;
    logic        mv;
    logic [5:0]  from;
    logic [5:0]  to;
    logic        jmp;
  } snap_t;

  typedef struct {
    logic [5:0] from;
    logic [5:0] to;
    logic       jmp;
  } mv_t;

  snap_t snap_q[$];
  mv_t   mv_q[$];
  int    checks = 0;
  int    failures = 0;
  bit    sample = 0;

  int m_cx, m_cy, m_sx, m_sy, m_mode;
  int m_fx, m_fy, m_tx, m_ty;
  bit m_j;
  bit m_turn;
  bit b_occ[8][8];
  bit b_red[8][8];
  bit b_king[8][8];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [5:0] loc(int x, int y);
    return {3'(x), 3'(y)};
  endfunction

  function automatic bit onb(int x, int y);
    return x >= 0 && x < 8 && y >= 0 && y < 8;
  endfunction

  function automatic bit own(int x, int y);
    return b_occ[x][y] && (b_red[x][y] == m_turn);
  endfunction

  // Four diagonal directions, men restricted to forward ones.
  function automatic void m_calc(input int sx, input int sy,
                                 output logic [27:0] lg,
                                 output logic [3:0] jf);
    int dx, dy, ax, ay, lx, ly;
    bit allowed;
    lg = '0;
    jf = '0;
    for (int k = 0; k < 4; k++) begin
      dx = (k % 2 == 0) ? 1 : -1;
      dy = (k < 2) ? 1 : -1;
      allowed = b_king[sx][sy] || (b_red[sx][sy] ? (k < 2) : (k >= 2));
      ax = sx + dx;
      ay = sy + dy;
      lx = ax + dx;
      ly = ay + dy;
      if (allowed && onb(ax, ay)) begin
        if (!b_occ[ax][ay]) begin
          lg[7*k +: 7] = {1'b1, loc(ax, ay)};
        end else if (b_red[ax][ay] != b_red[sx][sy] &&
                     onb(lx, ly) && !b_occ[lx][ly]) begin
          lg[7*k +: 7] = {1'b1, loc(lx, ly)};
          jf[k] = 1'b1;
        end
      end
    end
  endfunction

  function automatic void m_sel();
    logic [27:0] lg;
    logic [3:0]  jf;
    bit found, j;
    mv_t m;
    found = 0;
    j = 0;
    if (m_mode == M_IDLE) begin
      if (own(m_cx, m_cy)) begin
        m_mode = M_SEL;
        m_sx = m_cx;
        m_sy = m_cy;
      end
    end else if (m_mode == M_SEL) begin
      if (m_cx == m_sx && m_cy == m_sy) begin
        m_mode = M_IDLE;
      end else begin
        m_calc(m_sx, m_sy, lg, jf);
        for (int k = 0; k < 4; k++) begin
          if (lg[7*k+6] && lg[7*k +: 6] == loc(m_cx, m_cy)) begin
            found = 1;
            j = jf[k];
          end
        end
        if (found) begin
          m_mode = M_COM;
          m_fx = m_sx; m_fy = m_sy;
          m_tx = m_cx; m_ty = m_cy;
          m_j = j;
          m.from = loc(m_sx, m_sy);
          m.to = loc(m_cx, m_cy);
          m.jmp = j;
          mv_q.push_back(m);
        end else if (own(m_cx, m_cy)) begin
          m_sx = m_cx;
          m_sy = m_cy;
        end
      end
    end
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic apply_board();
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++)
        board_v[(x*8+y)*3 +: 3] = {b_occ[x][y], b_red[x][y], b_king[x][y]};
    turn = m_turn;
  endtask

  task automatic clear_board();
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++) begin
        b_occ[x][y] = 0; b_red[x][y] = 0; b_king[x][y] = 0;
      end
  endtask

  task automatic put(int x, int y, bit red, bit king);
    b_occ[x][y] = 1; b_red[x][y] = red; b_king[x][y] = king;
  endtask

  // mask = {sel, right, left, down, up}
  task automatic press(input logic [4:0] mask, input int hold);
    bit was_commit;
    was_commit = (m_mode == M_COM);
    if (mask[4]) m_sel();
    if (!was_commit) begin
      m_cx += int'(mask[3]) - int'(mask[2]);
      m_cy += int'(mask[0]) - int'(mask[1]);
      if (m_cx < 0) m_cx = 0;
      if (m_cx > 7) m_cx = 7;
      if (m_cy < 0) m_cy = 0;
      if (m_cy > 7) m_cy = 7;
    end
    {btn_sel, btn_right, btn_left, btn_down, btn_up} = mask;
    tick(hold);
    {btn_sel, btn_right, btn_left, btn_down, btn_up} = '0;
    tick(5);
  endtask

  task automatic goto_sq(int x, int y);
    logic [4:0] mask;
    int guard;
    guard = 0;
    while ((m_cx != x || m_cy != y) && guard < 20 && m_mode != M_COM) begin
      mask = '0;
      if (m_cx < x) mask[3] = 1; else if (m_cx > x) mask[2] = 1;
      if (m_cy < y) mask[0] = 1; else if (m_cy > y) mask[1] = 1;
      press(mask, 1);
      guard++;
    end
  endtask

  task automatic check_now(string nm);
    snap_t s;
    logic [3:0] jf;
    s.nm    = nm;
    s.cur   = loc(m_cx, m_cy);
    s.act   = (m_mode != M_IDLE);
    s.sel   = s.act ? loc(m_sx, m_sy) : s.cur;
    s.legal = '0;
    if (m_mode == M_SEL) m_calc(m_sx, m_sy, s.legal, jf);
    s.mv    = (m_mode == M_COM);
    s.from  = loc(m_fx, m_fy);
    s.to    = loc(m_tx, m_ty);
    s.jmp   = m_j;
    snap_q.push_back(s);
    sample = 1;
    tick(1);
    sample = 0;
  endtask

  task automatic do_ack(string nm);
    move_ack = 1;
    m_mode = M_IDLE;
    check_now(nm);
    move_ack = 0;
  endtask

  task automatic rnd_board();
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++) begin
        b_occ[x][y]  = ($urandom_range(0, 99) < 35);
        b_red[x][y]  = 1'($urandom_range(0, 1));
        b_king[x][y] = ($urandom_range(0, 3) == 0);
      end
    m_turn = 1'($urandom_range(0, 1));
    apply_board();
  endtask

  initial begin : monitor
    snap_t s;
    mv_t m;
    logic prev_mv;
    prev_mv = 1'b0;
    forever begin
      @(negedge clk);
      if (move_valid && !prev_mv) begin
        if (mv_q.size() == 0) begin
          chk("move_unexpected", 32'(move_valid), 32'd0);
        end else begin
          m = mv_q.pop_front();
          chk("move_from", 32'(move_from), 32'(m.from));
          chk("move_to", 32'(move_to), 32'(m.to));
          chk("move_jump", 32'(move_jump), 32'(m.jmp));
        end
      end
      prev_mv = move_valid;
      if (sample && snap_q.size() != 0) begin
        s = snap_q.pop_front();
        chk({s.nm, ".cursor"}, 32'(cursor_loc), 32'(s.cur));
        chk({s.nm, ".select_loc"}, 32'(select_loc), 32'(s.sel));
        chk({s.nm, ".active"}, 32'(select_active), 32'(s.act));
        chk({s.nm, ".legal"}, 32'(legal_move), 32'(s.legal));
        chk({s.nm, ".move_valid"}, 32'(move_valid), 32'(s.mv));
        if (s.mv) begin
          chk({s.nm, ".from"}, 32'(move_from), 32'(s.from));
          chk({s.nm, ".to"}, 32'(move_to), 32'(s.to));
          chk({s.nm, ".jump"}, 32'(move_jump), 32'(s.jmp));
        end
      end
    end
  end

  initial begin : watchdog
    #2400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stim
    logic [27:0] lg;
    logic [3:0]  jf;
    logic [4:0]  mask;
    int r, nv, pick, idx;
    int vk[4];
    bit done;
    rst = 0;
    {btn_sel, btn_right, btn_left, btn_down, btn_up} = '0;
    move_ack = 0;
    board_v = '0;
    m_cx = 0; m_cy = 0; m_sx = 0; m_sy = 0; m_mode = M_IDLE;
    m_fx = 0; m_fy = 0; m_tx = 0; m_ty = 0; m_j = 0;
    m_turn = 1;
    clear_board();
    apply_board();
    tick(3);
    chk("rst.cursor", 32'(cursor_loc), 32'd0);
    chk("rst.active", 32'(select_active), 32'd0);
    chk("rst.move_valid", 32'(move_valid), 32'd0);
    rst = 1;
    tick(2);
    check_now("after_reset");

    repeat (3) press(5'b00100, 2);
    repeat (9) press(5'b00001, 1);
    check_now("cursor_o07");
    press(5'b01100, 2);
    check_now("cursor_cancel");

    clear_board();
    put(2, 2, 1, 0);
    m_turn = 1;
    apply_board();
    goto_sq(2, 2);
    press(5'b10000, 3);
    check_now("select_22");
    chk("slot0_o33", 32'(legal_move[6:0]), 32'h5B);
    chk("slot1_o13", 32'(legal_move[13:7]), 32'h4B);
    chk("slots23_zero", 32'(legal_move[27:14]), 32'd0);
    goto_sq(5, 5);
    press(5'b10000, 1);
    check_now("sel_empty_stay");
    goto_sq(2, 2);
    press(5'b10000, 1);
    check_now("deselect");

    put(3, 3, 0, 0);
    apply_board();
    press(5'b10000, 1);
    check_now("select_jump");
    chk("slot0_jump_o44", 32'(legal_move[6:0]), 32'h64);
    goto_sq(4, 4);
    press(5'b10000, 2);
    check_now("commit_jump");
    tick(3);
    check_now("commit_hold");
    do_ack("after_ack");
    goto_sq(3, 3);
    press(5'b10000, 1);
    check_now("sel_opponent_idle");

    clear_board();
    put(7, 2, 1, 0);
    m_turn = 1;
    apply_board();
    goto_sq(7, 2);
    press(5'b10000, 1);
    check_now("select_72");
    chk("edge_slot0_off", 32'(legal_move[6:0]), 32'd0);
    chk("edge_slot1_o63", 32'(legal_move[13:7]), 32'h73);
    press(5'b10000, 1);
    clear_board();
    put(0, 0, 0, 0);
    m_turn = 0;
    apply_board();
    goto_sq(0, 0);
    press(5'b10000, 1);
    check_now("select_00_white");
    chk("corner_all_off", 32'(legal_move), 32'd0);
    press(5'b10000, 1);

    clear_board();
    put(2, 2, 1, 0);
    put(3, 3, 0, 0);
    m_turn = 1;
    apply_board();
    goto_sq(2, 2);
    press(5'b10000, 1);
    goto_sq(4, 4);
    press(5'b10000, 1);
    check_now("commit_again");
    #5;
    rst = 0;
    #1;
    chk("rst_async.move_valid", 32'(move_valid), 32'd0);
    chk("rst_async.active", 32'(select_active), 32'd0);
    chk("rst_async.cursor", 32'(cursor_loc), 32'd0);
    chk("rst_async.legal", 32'(legal_move), 32'd0);
    chk("rst_async.from_to", 32'({move_from, move_to, move_jump}), 32'd0);
    m_cx = 0; m_cy = 0; m_mode = M_IDLE;
    m_fx = 0; m_fy = 0; m_tx = 0; m_ty = 0; m_j = 0;
    tick(2);
    rst = 1;
    tick(3);
    check_now("post_reset");

    rnd_board();
    for (int it = 0; it < 120; it++) begin
      r = $urandom_range(0, 9);
      if (m_mode == M_COM && r < 5) begin
        tick($urandom_range(0, 3));
        do_ack($sformatf("rnd_ack%0d", it));
      end else if (m_mode == M_IDLE && r < 2) begin
        rnd_board();
      end else if (m_mode == M_IDLE && r < 6) begin
        done = 0;
        pick = $urandom_range(0, 63);
        for (int i = 0; i < 64; i++) begin
          idx = (pick + i) % 64;
          if (!done && own(idx / 8, idx % 8)) begin
            done = 1;
            goto_sq(idx / 8, idx % 8);
            press(5'b10000, $urandom_range(1, 3));
          end
        end
      end else if (m_mode == M_SEL && r < 6) begin
        m_calc(m_sx, m_sy, lg, jf);
        nv = 0;
        for (int k = 0; k < 4; k++)
          if (lg[7*k+6]) begin vk[nv] = k; nv++; end
        if (nv > 0) begin
          pick = vk[$urandom_range(0, nv - 1)];
          goto_sq(int'(lg[7*pick+3 +: 3]), int'(lg[7*pick +: 3]));
        end
        press(5'b10000, 1);
      end else begin
        mask = 5'($urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) mask[4] = 1;
        press(mask, $urandom_range(1, 4));
      end
      check_now($sformatf("rnd%0d", it));
    end

    tick(5);
    chk("snapshots_drained", 32'(snap_q.size()), 32'd0);
    chk("moves_drained", 32'(mv_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/move_controller.md
MOVE_CONTROLLER -- requirements
Module: move_controller

Interface
REQ-001 SHALL have port clk, input, 1, system clock (25 MHz pixel clock domain shared with display).
REQ-002 SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have ports btn_up/btn_down/btn_left/btn_right/btn_sel, input, 1 each, pre-debounced active-high buttons, asynchronous to clk.
REQ-004 SHALL have port serialized_board, input, 192; square {x,y} occupies bits [{x,y}*3+2 : {x,y}*3]; bit2 = occupied, bit1 = red, bit0 = king.
REQ-005 SHALL have port turn, input, 1; 1 = red to move, 0 = white.
REQ-006 SHALL have port move_ack, input, 1; game logic has consumed the move.
REQ-007 SHALL have port cursor_loc, output, 6, {x[2:0], y[2:0]}.
REQ-008 SHALL have port select_loc, output, 6, selected square.
REQ-009 SHALL have port select_active, output, 1, a piece is selected.
REQ-010 SHALL have port legal_move, output, 28; four 7-bit slots {valid, loc[5:0]}; slot k at [7k+6 : 7k].
REQ-011 SHALL have ports move_valid (1), move_from (6), move_to (6), move_jump (1), outputs, move request to game logic.

Function
REQ-012 SHALL pass each button through a 2-flop synchronizer and then a rising-edge detector; one action per press, regardless of hold length.
REQ-013 Cursor: up/down SHALL step y by +1/-1 and right/left SHALL step x by +1/-1, saturating at 0 and 7 with no wrap-around.
REQ-014 Opposing presses on the same axis in the same cycle SHALL cancel; the x and y axes SHALL update independently in the same cycle.
REQ-015 The cursor SHALL be frozen in COMMIT and movable in IDLE and SELECTED.
REQ-016 SHALL implement the FSM states IDLE, SELECTED, COMMIT.
REQ-017 IDLE: a sel edge on a square that is occupied with colour == turn SHALL go to SELECTED and latch select_loc = cursor_loc; any other sel edge SHALL be ignored.
REQ-018 SELECTED, sel edge resolved in priority order:
- cursor == select_loc -> IDLE (deselect);
- else cursor equals a valid legal_move slot -> COMMIT, latching move_from = select_loc, move_to = cursor, move_jump = that slot's jump flag;
- else cursor on another own piece -> stay SELECTED, reselect;
- otherwise ignore.
REQ-019 COMMIT: move_valid SHALL be 1 and move_from/move_to/move_jump SHALL be held stable; when move_ack = 1 at a rising edge -> IDLE, move_valid = 0 on the next cycle.
REQ-020 select_active SHALL be 1 exactly in SELECTED and COMMIT; while select_active = 0, select_loc SHALL equal cursor_loc.
REQ-021 Slot directions SHALL be: slot0 (+x,+y), slot1 (-x,+y), slot2 (+x,-y), slot3 (-x,-y).
- Red men use slots 0-1; white men use slots 2-3; kings use all four.
REQ-022 Per allowed slot:
- adjacent square on-board and empty -> valid, loc = adjacent, jump flag 0;
- else adjacent holds an opponent and the landing square two steps away is on-board and empty -> valid, loc = landing, jump flag 1;
- else valid = 0, loc = 0.
REQ-023 legal_move SHALL be registered and recomputed every cycle in SELECTED from the current board and select_loc (valid one cycle after entering SELECTED); it SHALL be all-zero in IDLE and COMMIT.
REQ-024 Off-board checks SHALL use 4-bit signed arithmetic on x and y; no 3-bit wrap SHALL ever yield a valid slot.
REQ-025 A sel edge in the same cycle as a cursor move SHALL evaluate against the pre-move cursor_loc.
REQ-026 A sel edge in the first SELECTED cycle SHALL compare against the all-zero legal_move, so that press cannot commit.

Reset
REQ-027 While rst = 0: state = IDLE, cursor_loc = 6'o00, select_loc = 6'o00, select_active = 0, legal_move = 0, move_valid = 0, move_from = 0, move_to = 0, move_jump = 0, synchronizer/edge flops = 0.
REQ-028 Reset asserted mid-COMMIT SHALL drop move_valid asynchronously, with no pending move after release.

Verification
REQ-029 Cursor at 6'o00: 3 btn_left + 9 btn_up presses -> cursor_loc = 6'o07; then 1 btn_right with 1 btn_left in the same cycle -> cursor_loc unchanged at 6'o07.
REQ-030 Red man at {2,2}, turn = 1, board otherwise empty: select -> select_loc = 6'o22, select_active = 1, slot0 = {1, 6'o33}, slot1 = {1, 6'o13}, slots 2-3 = 0.
REQ-031 Red man at {2,2}, white at {3,3}, {4,4} empty: slot0 = {1, 6'o44} with jump flag 1; sel on {4,4} -> move_valid = 1, move_from = 6'o22, move_to = 6'o44, move_jump = 1, held until move_ack; IDLE one cycle after ack.
REQ-032 Red man at {7,2}: slot0 invalid (off-board) and slot1 = {1, 6'o63}; white man at {0,0}: slots 2-3 both invalid.
REQ-033 Sel on an opponent piece in IDLE -> no state change; sel on an empty non-legal square in SELECTED -> stays SELECTED; re-press sel on select_loc -> IDLE, legal_move = 0.
REQ-034 rst pulsed low during COMMIT -> move_valid = 0 immediately and all outputs at REQ-027 values.
